async_fifo_gray: RTL and testbench

Parametrised dual-clock FIFO that replaces the fixed 8×4 counter-based FIFO in the Tiny Tapeout designs. It uses Gray-coded pointers with multi-flop synchronisers, so every flag is derived safely in its own clock domain. It also provides almost-full/almost-empty thresholds, per-side fill levels, overflow/underflow pulses and internally synchronised reset release. It sits between the `ui_in`/`uio_in` pin decode and the `uo_out` mux of the top-level wrapper.

---
 rtl/async_fifo_gray.sv | 152 +++++++++++++++
 tb/tb_async_fifo_gray.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_gray.sv
// async_fifo_gray: dual-clock FIFO with Gray-coded pointers crossing through
// SYNC-stage synchronisers. Every flag, level and almost-threshold is registered
// in its own clock domain. Because each side sees a lagging copy of the other
// side's pointer, the writer's view is never emptier than the truth and the
// reader's view is never fuller. Reset asserts asynchronously in both domains
// and is released through a 2-flop synchroniser per domain.
module async_fifo_gray #(
   parameter int DW        = 8,
   parameter int AW        = 3,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 2,
   parameter int SYNC      = 2
) (
   input  logic          wclk,
   input  logic          rclk,
   input  logic          rst,
   input  logic          w_en,
   input  logic [DW-1:0] w_data,
   output logic          w_full,
   output logic          w_afull,
   output logic [AW:0]   w_level,
   output logic          w_overflow,
   input  logic          r_en,
   output logic [DW-1:0] r_data,
   output logic          r_empty,
   output logic          r_aempty,
   output logic [AW:0]   r_level,
   output logic          r_underflow
);

   localparam logic [AW:0] AFULL_LV  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_LV = (AW+1)'(AEMPTY_TH);

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [DW-1:0] r_mem [2**AW];

   logic [1:0]    r_wr_rst_sync;
   logic [1:0]    r_rd_rst_sync;
   logic          w_wr_rst;
   logic          w_rd_rst;

   logic [AW:0]   r_wbin;
   logic [AW:0]   r_wgray;
   logic [AW:0]   r_rq [SYNC];
   logic [AW:0]   r_rbin;
   logic [AW:0]   r_rgray;
   logic [AW:0]   r_wq [SYNC];

   logic          w_winc;
   logic [AW:0]   w_wbin_next;
   logic [AW:0]   w_wgray_next;
   logic [AW:0]   w_rgray_s;
   logic [AW:0]   w_wlevel_next;

   logic          w_rinc;
   logic [AW:0]   w_rbin_next;
   logic [AW:0]   w_rgray_next;
   logic [AW:0]   w_wgray_s;
   logic [AW:0]   w_rlevel_next;

   // Write-domain reset: asserts immediately, releases after two wclk edges.
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) r_wr_rst_sync <= 2'b11;
      else     r_wr_rst_sync <= {r_wr_rst_sync[0], 1'b0};
   end

   // Read-domain reset: asserts immediately, releases after two rclk edges.
   always_ff @(posedge rclk or posedge rst) begin
      if (rst) r_rd_rst_sync <= 2'b11;
      else     r_rd_rst_sync <= {r_rd_rst_sync[0], 1'b0};
   end

   assign w_wr_rst = r_wr_rst_sync[1];
   assign w_rd_rst = r_rd_rst_sync[1];

   // Write-side next-state: pointer advance, full compare and writer's level.
   assign w_winc        = w_en & ~w_full;
   assign w_wbin_next   = r_wbin + {{AW{1'b0}}, w_winc};
   assign w_wgray_next  = bin2gray(w_wbin_next);
   assign w_rgray_s     = r_rq[SYNC-1];
   assign w_wlevel_next = w_wbin_next - gray2bin(w_rgray_s);

   // Read-side next-state: pointer advance, empty compare and reader's level.
   assign w_rinc        = r_en & ~r_empty;
   assign w_rbin_next   = r_rbin + {{AW{1'b0}}, w_rinc};
   assign w_rgray_next  = bin2gray(w_rbin_next);
   assign w_wgray_s     = r_wq[SYNC-1];
   assign w_rlevel_next = gray2bin(w_wgray_s) - w_rbin_next;

   // Storage write; the array is left unreset on purpose.
   always_ff @(posedge wclk) begin
      if (w_winc) r_mem[r_wbin[AW-1:0]] <= w_data;
   end

   // Write domain: pointers, read-pointer synchroniser and writer flags.
   always_ff @(posedge wclk or posedge w_wr_rst) begin
      if (w_wr_rst) begin
         r_wbin     <= '0;
         r_wgray    <= '0;
         for (int i = 0; i < SYNC; i++) r_rq[i] <= '0;
         w_full     <= 1'b0;
         w_afull    <= 1'b0;
         w_level    <= '0;
         w_overflow <= 1'b0;
      end else begin
         r_rq[0] <= r_rgray;
         for (int i = 1; i < SYNC; i++) r_rq[i] <= r_rq[i-1];
         r_wbin     <= w_wbin_next;
         r_wgray    <= w_wgray_next;
         // Full when the writer is exactly one lap ahead: top two Gray bits differ.
         w_full     <= (w_wgray_next == {~w_rgray_s[AW:AW-1], w_rgray_s[AW-2:0]});
         w_level    <= w_wlevel_next;
         w_afull    <= (w_wlevel_next >= AFULL_LV);
         w_overflow <= w_en & w_full;
      end
   end

   // Read domain: pointers, write-pointer synchroniser, data and reader flags.
   always_ff @(posedge rclk or posedge w_rd_rst) begin
      if (w_rd_rst) begin
         r_rbin      <= '0;
         r_rgray     <= '0;
         for (int i = 0; i < SYNC; i++) r_wq[i] <= '0;
         r_empty     <= 1'b1;
         r_aempty    <= 1'b1;
         r_level     <= '0;
         r_data      <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_wq[0] <= r_wgray;
         for (int i = 1; i < SYNC; i++) r_wq[i] <= r_wq[i-1];
         r_rbin      <= w_rbin_next;
         r_rgray     <= w_rgray_next;
         r_empty     <= (w_rgray_next == w_wgray_s);
         r_level     <= w_rlevel_next;
         r_aempty    <= (w_rlevel_next <= AEMPTY_LV);
         r_underflow <= r_en & r_empty;
         if (w_rinc) r_data <= r_mem[r_rbin[AW-1:0]];
      end
   end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed bench for async_fifo_gray at DW=8, AW=3, SYNC=2.
module tb_async_fifo_gray;

   logic       wclk, rclk, rst;
   logic       w_en, r_en;
   logic [7:0] w_data, r_data;
   logic       w_full, w_afull, w_overflow;
   logic       r_empty, r_aempty, r_underflow;
   logic [3:0] w_level, r_level;

   int total = 0;
   int bad   = 0;

   int wlo = 5, whi = 5, rlo = 14, rhi = 13;

   async_fifo_gray #(.DW(8), .AW(3), .AFULL_TH(6), .AEMPTY_TH(2), .SYNC(2)) dut (
      .wclk(wclk), .rclk(rclk), .rst(rst),
      .w_en(w_en), .w_data(w_data), .w_full(w_full), .w_afull(w_afull),
      .w_level(w_level), .w_overflow(w_overflow),
      .r_en(r_en), .r_data(r_data), .r_empty(r_empty), .r_aempty(r_aempty),
      .r_level(r_level), .r_underflow(r_underflow)
   );

   initial begin
      wclk = 0;
      forever begin #(wlo) wclk = 1; #(whi) wclk = 0; end
   end

   initial begin
      rclk = 0;
      forever begin #(rlo) rclk = 1; #(rhi) rclk = 0; end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wr_one(input logic [7:0] d);
      @(negedge wclk);
      w_en = 1; w_data = d;
      @(posedge wclk); #1;
      w_en = 0;
   endtask

   task automatic rd_one;
      @(negedge rclk);
      r_en = 1;
      @(posedge rclk); #1;
      r_en = 0;
   endtask

   task automatic do_reset;
      rst = 1;
      #20;
      @(negedge wclk);
      rst = 0;
      repeat (4) @(posedge wclk);
      repeat (4) @(posedge rclk);
      #1;
   endtask

   task automatic test_reset;
      int n;
      rst = 1; w_en = 0; r_en = 0; w_data = 0;
      do_reset();
      wr_one(8'h11);
      n = 0;
      while (r_empty && n < 20) begin @(posedge rclk); #1; n++; end
      rd_one();
      total++; if (r_data !== 8'h11) begin bad++; $display("FAIL pre_read: got=%h exp=11", r_data); end
      wr_one(8'h22);
      @(posedge wclk); #3;
      rst = 1; #1;
      total++; if (w_full !== 1'b0)      begin bad++; $display("FAIL rst_w_full: got=%b exp=0", w_full); end
      total++; if (w_afull !== 1'b0)     begin bad++; $display("FAIL rst_w_afull: got=%b exp=0", w_afull); end
      total++; if (w_level !== 4'd0)     begin bad++; $display("FAIL rst_w_level: got=%0d exp=0", w_level); end
      total++; if (w_overflow !== 1'b0)  begin bad++; $display("FAIL rst_w_overflow: got=%b exp=0", w_overflow); end
      total++; if (r_empty !== 1'b1)     begin bad++; $display("FAIL rst_r_empty: got=%b exp=1", r_empty); end
      total++; if (r_aempty !== 1'b1)    begin bad++; $display("FAIL rst_r_aempty: got=%b exp=1", r_aempty); end
      total++; if (r_level !== 4'd0)     begin bad++; $display("FAIL rst_r_level: got=%0d exp=0", r_level); end
      total++; if (r_data !== 8'h00)     begin bad++; $display("FAIL rst_r_data: got=%h exp=00", r_data); end
      total++; if (r_underflow !== 1'b0) begin bad++; $display("FAIL rst_r_underflow: got=%b exp=0", r_underflow); end
      #10;
      @(negedge wclk);
      rst = 0; w_en = 1; w_data = 8'h33;
      @(posedge wclk); #1;
      total++; if (w_level !== 4'd0) begin bad++; $display("FAIL release_edge1: w_level got=%0d exp=0", w_level); end
      @(posedge wclk); #1;
      total++; if (w_level !== 4'd0) begin bad++; $display("FAIL release_edge2: w_level got=%0d exp=0", w_level); end
      @(posedge wclk); #1;
      total++; if (w_level !== 4'd1) begin bad++; $display("FAIL release_edge3: w_level got=%0d exp=1", w_level); end
      w_en = 0;
   endtask

   task automatic test_fill;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         wr_one(8'(i));
         total++; if (w_level !== 4'(i)) begin bad++; $display("FAIL fill_level[%0d]: got=%0d exp=%0d", i, w_level, i); end
         total++; if (w_full !== (i == 8)) begin bad++; $display("FAIL fill_full[%0d]: got=%b exp=%b", i, w_full, (i == 8)); end
         total++; if (w_afull !== (i >= 6)) begin bad++; $display("FAIL fill_afull[%0d]: got=%b exp=%b", i, w_afull, (i >= 6)); end
      end
   endtask

   task automatic test_overflow;
      wr_one(8'hAA);
      total++; if (w_overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got=%b exp=1", w_overflow); end
      total++; if (w_full !== 1'b1)     begin bad++; $display("FAIL ovf_full: got=%b exp=1", w_full); end
      total++; if (w_level !== 4'd8)    begin bad++; $display("FAIL ovf_level: got=%0d exp=8", w_level); end
      @(posedge wclk); #1;
      total++; if (w_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got=%b exp=0", w_overflow); end
   endtask

   task automatic test_drain;
      int n;
      n = 0;
      while (r_level !== 4'd8 && n < 40) begin @(posedge rclk); #1; n++; end
      total++; if (r_level !== 4'd8) begin bad++; $display("FAIL drain_wait: r_level got=%0d exp=8", r_level); end
      for (int i = 1; i <= 8; i++) begin
         rd_one();
         total++; if (r_data !== 8'(i)) begin bad++; $display("FAIL drain_data[%0d]: got=%h exp=%h", i, r_data, 8'(i)); end
         total++; if (r_level !== 4'(8 - i)) begin bad++; $display("FAIL drain_level[%0d]: got=%0d exp=%0d", i, r_level, 8 - i); end
         total++; if (r_empty !== (i == 8)) begin bad++; $display("FAIL drain_empty[%0d]: got=%b exp=%b", i, r_empty, (i == 8)); end
         total++; if (r_aempty !== (i >= 6)) begin bad++; $display("FAIL drain_aempty[%0d]: got=%b exp=%b", i, r_aempty, (i >= 6)); end
      end
      repeat (6) @(posedge wclk); #1;
      total++; if (w_full !== 1'b0)  begin bad++; $display("FAIL drain_wfull: got=%b exp=0", w_full); end
      total++; if (w_level !== 4'd0) begin bad++; $display("FAIL drain_wlevel: got=%0d exp=0", w_level); end
   endtask

   task automatic test_underflow;
      @(negedge rclk);
      r_en = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge rclk); #1;
         total++; if (r_underflow !== 1'b1) begin bad++; $display("FAIL udf_pulse[%0d]: got=%b exp=1", k, r_underflow); end
         total++; if (r_data !== 8'h08)     begin bad++; $display("FAIL udf_hold[%0d]: got=%h exp=08", k, r_data); end
      end
      r_en = 0;
      @(posedge rclk); #1;
      total++; if (r_underflow !== 1'b0) begin bad++; $display("FAIL udf_clear: got=%b exp=0", r_underflow); end
   endtask

   task automatic test_wrap;
      wlo = 5; whi = 5; rlo = 7; rhi = 6;
      fork
         begin
            int wv;
            int it;
            wv = 0; it = 0;
            while (wv < 40 && it < 3000) begin
               @(negedge wclk);
               if (!w_full) begin w_en = 1; w_data = 8'(wv); wv++; end
               else w_en = 0;
               @(posedge wclk); #1;
               it++;
            end
            w_en = 0;
         end
         begin
            int  rv;
            int  it;
            logic ok;
            rv = 0; it = 0;
            while (rv < 40 && it < 3000) begin
               @(negedge rclk);
               ok = !r_empty;
               r_en = 1;
               @(posedge rclk); #1;
               if (ok) begin
                  total++;
                  if (r_data !== 8'(rv)) begin bad++; $display("FAIL wrap_data[%0d]: got=%h exp=%h", rv, r_data, 8'(rv)); end
                  rv++;
               end
               it++;
            end
            r_en = 0;
            total++; if (rv != 40) begin bad++; $display("FAIL wrap_count: got=%0d exp=40", rv); end
         end
      join
      repeat (4) @(posedge rclk); #1;
      total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got=%b exp=1", r_empty); end
   endtask

   task automatic test_reset_mid;
      int n;
      for (int i = 0; i < 5; i++) wr_one(8'h31 + 8'(i));
      n = 0;
      while (r_level !== 4'd5 && n < 40) begin @(posedge rclk); #1; n++; end
      total++; if (r_level !== 4'd5) begin bad++; $display("FAIL mid_wait: r_level got=%0d exp=5", r_level); end
      rd_one();
      total++; if (r_data !== 8'h31) begin bad++; $display("FAIL mid_read1: got=%h exp=31", r_data); end
      rd_one();
      total++; if (r_data !== 8'h32) begin bad++; $display("FAIL mid_read2: got=%h exp=32", r_data); end
      @(negedge wclk);
      rst = 1; #1;
      total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty: got=%b exp=1", r_empty); end
      total++; if (w_level !== 4'd0) begin bad++; $display("FAIL mid_rst_wlevel: got=%0d exp=0", w_level); end
      do_reset();
      wr_one(8'h55);
      n = 0;
      while (r_empty && n < 20) begin @(posedge rclk); #1; n++; end
      total++; if (r_empty !== 1'b0) begin bad++; $display("FAIL mid_visible: r_empty got=%b exp=0", r_empty); end
      rd_one();
      total++; if (r_data !== 8'h55) begin bad++; $display("FAIL mid_after: got=%h exp=55", r_data); end
      total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL mid_after_empty: got=%b exp=1", r_empty); end
   endtask

   initial begin
      rst = 1; w_en = 0; r_en = 0; w_data = 0;
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_underflow();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
